// File: rtl/dram_arbiter_if.sv
// Bundle of requester-side and DRAM-side signals around the DRAM arbiter.
// slave = arbiter view, master = requesters plus DRAM controller view.
interface dram_arbiter_if #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 32
);
  logic              core_start;
  logic              core_end;
  logic              core_req_valid;
  logic              core_req_rw;
  logic [31:0]       core_req_addr;
  logic [DATA_W-1:0] core_req_wdata;
  logic              core_done;

  logic              io_req_valid;
  logic              io_req_rw;
  logic [31:0]       io_req_addr;
  logic [DATA_W-1:0] io_req_wdata;
  logic              io_done;

  logic [DATA_W-1:0] rdata;
  logic              owner_io;

  logic [ADDR_W-1:0] addr_dram;
  logic [DATA_W-1:0] din_dram;
  logic              rw_dram;
  logic              valid_dram;
  logic [DATA_W-1:0] dout_dram;
  logic              ready_dram;

  modport slave (
    input  core_start, core_end, core_req_valid, core_req_rw, core_req_addr, core_req_wdata,
    input  io_req_valid, io_req_rw, io_req_addr, io_req_wdata,
    input  dout_dram, ready_dram,
    output core_done, io_done, rdata, owner_io,
    output addr_dram, din_dram, rw_dram, valid_dram
  );

  modport master (
    output core_start, core_end, core_req_valid, core_req_rw, core_req_addr, core_req_wdata,
    output io_req_valid, io_req_rw, io_req_addr, io_req_wdata,
    output dout_dram, ready_dram,
    input  core_done, io_done, rdata, owner_io,
    input  addr_dram, din_dram, rw_dram, valid_dram
  );
endinterface

// File: rtl/dram_arbiter.sv
// Shares one DRAM word port between the core memory stage and the io block,
// one word per grant, with a starvation limit for io while the core runs.
module dram_arbiter #(
  parameter int ADDR_W   = 27,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input logic          clk,
  input logic          rst,
  dram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  localparam int              WCW      = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0]  WAIT_MAX = WCW'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [WCW-1:0]    wait_q, wait_d;
  logic              owner_io_q, owner_io_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              core_pri;
  logic              grant_io;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      owner_io_q <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      owner_io_q <= owner_io_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    owner_io_d = owner_io_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    din_d      = din_q;
    rdata_d    = rdata_q;
    // Core keeps priority while running, until io has waited MAX_WAIT grants.
    core_pri   = bus.core_start && !bus.core_end && (wait_q != WAIT_MAX);
    grant_io   = bus.io_req_valid && (!bus.core_req_valid || !core_pri);

    case (state_q)
      IDLE: begin
        if (!bus.io_req_valid) begin
          wait_d = '0;
        end
        if (bus.core_req_valid || bus.io_req_valid) begin
          state_d    = ISSUE;
          owner_io_d = grant_io;
          if (grant_io) begin
            wait_d = '0;
            rw_d   = bus.io_req_rw;
            addr_d = bus.io_req_addr[ADDR_W+1:2];
            din_d  = bus.io_req_wdata;
          end else begin
            if (bus.io_req_valid && (wait_q != WAIT_MAX)) begin
              wait_d = wait_q + WCW'(1);
            end
            rw_d   = bus.core_req_rw;
            addr_d = bus.core_req_addr[ADDR_W+1:2];
            din_d  = bus.core_req_wdata;
          end
        end
      end
      ISSUE: begin
        if (bus.ready_dram) begin
          if (!rw_q) begin
            rdata_d = bus.dout_dram;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.valid_dram = (state_q == ISSUE);
  assign bus.core_done  = (state_q == RESP) && !owner_io_q;
  assign bus.io_done    = (state_q == RESP) && owner_io_q;
  assign bus.rdata      = rdata_q;
  assign bus.owner_io   = owner_io_q;
  assign bus.addr_dram  = addr_q;
  assign bus.din_dram   = din_q;
  assign bus.rw_dram    = rw_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Random two-requester traffic against a transaction-level model of the arbiter,
// plus directed read, starvation-limit, core_end and mid-transfer reset scenarios.
module tb_dram_arbiter;
  localparam int ADDR_W   = 27;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: where the current transaction is (0 waiting for a grant, 1 on the bus, 2 done)
  int                phase;
  int                wait_m;
  bit                cur_io;
  bit                exp_valid, exp_cdone, exp_idone, exp_owner, exp_rw;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_din, exp_rdata;

  bit cpend, ipend;
  int p_core, p_io, p_ready, cs_mode;
  bit fixed;
  int mdl_cdone, mdl_idone, obs_cdone, obs_idone;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [ADDR_W-1:0] word_of(input logic [31:0] byte_addr);
    return ADDR_W'(byte_addr / 4);
  endfunction

  task automatic clear_model();
    phase     = 0;
    wait_m    = 0;
    cur_io    = 1'b0;
    exp_valid = 1'b0;
    exp_cdone = 1'b0;
    exp_idone = 1'b0;
    exp_owner = 1'b0;
    exp_rw    = 1'b0;
    exp_addr  = '0;
    exp_din   = '0;
    exp_rdata = '0;
  endtask

  task automatic check_outputs();
    check("valid_dram", bus.valid_dram, exp_valid);
    check("core_done",  bus.core_done,  exp_cdone);
    check("io_done",    bus.io_done,    exp_idone);
    check("owner_io",   bus.owner_io,   exp_owner);
    check("rw_dram",    bus.rw_dram,    exp_rw);
    check("addr_dram",  bus.addr_dram,  exp_addr);
    check("din_dram",   bus.din_dram,   exp_din);
    check("rdata",      bus.rdata,      exp_rdata);
    if (bus.core_done) obs_cdone++;
    if (bus.io_done)   obs_idone++;
  endtask

  // Requesters: hold a request until the model says it is done, then maybe issue another.
  task automatic drive();
    if (exp_cdone) cpend = 1'b0;
    if (exp_idone) ipend = 1'b0;
    if (!cpend && ($urandom_range(99) < p_core)) begin
      cpend              = 1'b1;
      bus.core_req_rw    = fixed ? 1'b0 : 1'($urandom_range(1));
      bus.core_req_addr  = fixed ? 32'h0000_0010 : $urandom();
      bus.core_req_wdata = $urandom();
    end
    if (!ipend && ($urandom_range(99) < p_io)) begin
      ipend            = 1'b1;
      bus.io_req_rw    = 1'($urandom_range(1));
      bus.io_req_addr  = $urandom();
      bus.io_req_wdata = $urandom();
    end
    bus.core_req_valid = cpend;
    bus.io_req_valid   = ipend;
    case (cs_mode)
      1: begin bus.core_start = 1'b1; bus.core_end = 1'b0; end
      2: begin bus.core_start = 1'b1; bus.core_end = 1'b1; end
      default: begin
        bus.core_start = ($urandom_range(99) < 75);
        bus.core_end   = ($urandom_range(99) < 20);
      end
    endcase
    bus.ready_dram = ($urandom_range(99) < p_ready);
    bus.dout_dram  = fixed ? 32'hDEAD_BEEF : $urandom();
  endtask

  // Predict next-cycle outputs from the inputs just driven.
  task automatic advance();
    bit cv, iv;
    cv = bus.core_req_valid;
    iv = bus.io_req_valid;
    exp_cdone = 1'b0;
    exp_idone = 1'b0;
    case (phase)
      0: begin
        if (!iv) wait_m = 0;
        if (cv || iv) begin
          if (cv && iv) cur_io = !(bus.core_start && !bus.core_end && wait_m < MAX_WAIT);
          else          cur_io = iv;
          if (cur_io)  wait_m = 0;
          else if (iv) wait_m = (wait_m + 1 > MAX_WAIT) ? MAX_WAIT : wait_m + 1;
          exp_owner = cur_io;
          exp_rw    = cur_io ? bus.io_req_rw : bus.core_req_rw;
          exp_addr  = word_of(cur_io ? bus.io_req_addr : bus.core_req_addr);
          exp_din   = cur_io ? bus.io_req_wdata : bus.core_req_wdata;
          exp_valid = 1'b1;
          phase     = 1;
        end
      end
      1: begin
        if (bus.ready_dram) begin
          exp_valid = 1'b0;
          if (!exp_rw) exp_rdata = bus.dout_dram;
          if (cur_io) begin exp_idone = 1'b1; mdl_idone++; end
          else        begin exp_cdone = 1'b1; mdl_cdone++; end
          $display("txn %s %s addr=%h data=%h", cur_io ? "io  " : "core", exp_rw ? "wr" : "rd",
                   exp_addr, exp_rw ? exp_din : bus.dout_dram);
          phase = 2;
        end
      end
      default: phase = 0;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_outputs();
    drive();
    advance();
  endtask

  // Reset asserted between edges: outputs must clear without a clock edge.
  task automatic reset_now();
    @(negedge clk);
    rst = 1'b1;
    #1;
    clear_model();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
    drive();
    advance();
  endtask

  int c0, i0, oc0, oi0;

  initial begin
    rst                = 1'b1;
    bus.core_start     = 1'b0;
    bus.core_end       = 1'b0;
    bus.core_req_valid = 1'b0;
    bus.core_req_rw    = 1'b0;
    bus.core_req_addr  = '0;
    bus.core_req_wdata = '0;
    bus.io_req_valid   = 1'b0;
    bus.io_req_rw      = 1'b0;
    bus.io_req_addr    = '0;
    bus.io_req_wdata   = '0;
    bus.dout_dram      = '0;
    bus.ready_dram     = 1'b0;
    cpend = 1'b0; ipend = 1'b0;
    mdl_cdone = 0; mdl_idone = 0; obs_cdone = 0; obs_idone = 0;
    clear_model();

    // Directed core read at byte address 0x10, zero-wait DRAM.
    fixed = 1'b1; p_core = 100; p_io = 0; p_ready = 100; cs_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
    drive();
    advance();
    repeat (4) step();
    check("t1_rdata", bus.rdata, 32'hDEAD_BEEF);
    check("t1_addr",  bus.addr_dram, 27'd4);
    fixed = 1'b0;

    // Mixed random traffic with a stalling DRAM.
    p_core = 50; p_io = 50; p_ready = 40; cs_mode = 0;
    repeat (1200) step();

    // io starvation limit: core always requesting, io always requesting.
    p_core = 100; p_io = 100; p_ready = 100; cs_mode = 1;
    repeat (6) step();
    oc0 = obs_cdone; oi0 = obs_idone; c0 = mdl_cdone; i0 = mdl_idone;
    repeat (60) step();
    check("maxwait_io_served", obs_idone - oi0, mdl_idone - i0);
    check("maxwait_core_served", obs_cdone - oc0, mdl_cdone - c0);
    check("maxwait_io_nonzero", (obs_idone - oi0) > 0, 1'b1);

    // core_end set: io wins every contested grant.
    cs_mode = 2;
    repeat (6) step();
    oc0 = obs_cdone; oi0 = obs_idone;
    repeat (40) step();
    check("coreend_core_none", obs_cdone - oc0, 0);
    check("coreend_io_served", (obs_idone - oi0) > 0, 1'b1);

    // Reset in the middle of a stalled core transfer, then reissue.
    p_core = 100; p_io = 0; p_ready = 0; cs_mode = 1;
    repeat (6) step();
    check("pre_reset_valid", bus.valid_dram, 1'b1);
    oc0 = obs_cdone;
    reset_now();
    check("reset_no_done", obs_cdone - oc0, 0);
    p_ready = 100;
    repeat (6) step();
    check("reissue_done", (obs_cdone - oc0) > 0, 1'b1);

    // More random traffic, including a reset under load.
    p_core = 60; p_io = 60; p_ready = 50; cs_mode = 0;
    repeat (300) step();
    reset_now();
    repeat (300) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
